ether_rx_framer: RTL and testbench

- Parametrised RMII receive framer; successor to the fixed dibit-out ether receiver.
- Sits between the RMII pins (crsdv/rxd, already synchronised to clk) and downstream frame logic.
- Strips preamble/SFD, packs data dibits LSB-first into OUT_W-bit words, and flags each frame end with a one-cycle status pulse (alignment, length, optional FCS check).

---
 rtl/ether_pkg.sv | 36 +++
 rtl/ether_rx_framer_if.sv | 24 ++
 rtl/crc32_dibit.sv | 25 ++
 rtl/ether_rx_framer.sv | 155 +++++++++++++++
 tb/tb_ether_rx_framer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII receive framer.
// The CRC step function is used only when ETHER_RX_FCS_CHECK_EN is defined.
package ether_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_e;

    localparam logic [1:0]  PRE_DIBIT_DEF = 2'b01;
    localparam logic [1:0]  SFD_DIBIT_DEF = 2'b11;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

    typedef struct packed {
        logic        err_align;
        logic        err_long;
        logic        fcs_ok;
        logic [15:0] dibit_cnt;
    } rx_status_t;

    // Reflected CRC-32 advanced by one dibit, bit 0 first.
    function automatic logic [31:0] crc32_dibit_step(input logic [31:0] crc,
                                                     input logic [1:0]  dibit);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            c = (c[0] ^ dibit[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ether_rx_framer_if.sv
// RMII receive side plus framed word/status outputs of ether_rx_framer.
interface ether_rx_framer_if #(
    parameter int unsigned OUT_W = 8
);
    logic             crsdv;
    logic [1:0]       rxd;
    logic             axiov;
    logic [OUT_W-1:0] axiod;
    logic             done;
    logic             err_align;
    logic             err_long;
    logic             fcs_ok;
    logic [15:0]      dibit_cnt;

    modport master (
        output crsdv, rxd,
        input  axiov, axiod, done, err_align, err_long, fcs_ok, dibit_cnt
    );

    modport slave (
        input  crsdv, rxd,
        output axiov, axiod, done, err_align, err_long, fcs_ok, dibit_cnt
    );
endinterface

// File: rtl/crc32_dibit.sv
// Dibit-serial reflected CRC-32 register; init has priority over en.
module crc32_dibit
    import ether_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_q <= CRC32_INIT;
        end else if (en) begin
            crc_q <= crc32_dibit_step(crc_q, dibit);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ether_rx_framer.sv
// RMII receive framer: strips preamble/SFD, packs dibits LSB-first into OUT_W words.
// Define ETHER_RX_FCS_CHECK_EN to add the FCS residue check; otherwise fcs_ok is 0.
module ether_rx_framer
    import ether_pkg::*;
#(
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned MIN_PRE    = 24,
    parameter int unsigned MAX_DIBITS = 6104,
    parameter logic [1:0]  PRE_DIBIT  = PRE_DIBIT_DEF,
    parameter logic [1:0]  SFD_DIBIT  = SFD_DIBIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ether_rx_framer_if.slave rx
);

    localparam int unsigned SLOTS  = OUT_W / 2;
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_e           state_q;
    logic [5:0]       pre_cnt_q;
    logic [SLOT_W-1:0] slot_q;
    logic [OUT_W-1:0] buf_q;
    logic [15:0]      cnt_q;
    logic             long_q;
    logic             axiov_q;
    logic [OUT_W-1:0] axiod_q;
    logic             done_q;
    rx_status_t       status_q;

    logic [OUT_W-1:0] word_d;
    logic [15:0]      cnt_d;
    logic             too_long_c;
    logic             last_slot_c;
    logic             sfd_accept_c;
    logic             data_en_c;
    logic             fcs_ok_c;
    rx_status_t       status_d;

    // Next word image, running count and frame-end status seen by the current dibit.
    always_comb begin
        word_d                        = buf_q;
        word_d[{slot_q, 1'b0} +: 2]   = rx.rxd;
        cnt_d        = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        too_long_c   = (32'(cnt_d) > MAX_DIBITS);
        last_slot_c  = (slot_q == SLOT_W'(SLOTS - 1));
        sfd_accept_c = (state_q == PRE) && rx.crsdv && (rx.rxd == SFD_DIBIT)
                       && (32'(pre_cnt_q) >= MIN_PRE);
        data_en_c    = (state_q == DATA) && rx.crsdv;
        status_d.err_align = (slot_q != '0);
        status_d.err_long  = long_q;
        status_d.fcs_ok    = fcs_ok_c;
        status_d.dibit_cnt = cnt_q;
    end

`ifdef ETHER_RX_FCS_CHECK_EN
    logic [31:0] crc_c;

    crc32_dibit u_crc (
        .clk   (clk),
        .rst   (rst),
        .init  (sfd_accept_c),
        .en    (data_en_c),
        .dibit (rx.rxd),
        .crc   (crc_c)
    );

    assign fcs_ok_c = (crc_c == CRC32_RESIDUE);
`else
    assign fcs_ok_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_cnt_q <= '0;
            slot_q    <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            long_q    <= 1'b0;
            axiov_q   <= 1'b0;
            axiod_q   <= '0;
            done_q    <= 1'b0;
            status_q  <= '0;
        end else begin
            axiov_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rx.crsdv) begin
                        long_q    <= 1'b0;
                        pre_cnt_q <= 6'd1;
                        state_q   <= (rx.rxd == PRE_DIBIT) ? PRE : DROP;
                    end
                end
                PRE: begin
                    if (!rx.crsdv) begin
                        state_q <= IDLE;
                    end else if (rx.rxd == PRE_DIBIT) begin
                        if (pre_cnt_q != 6'd63) pre_cnt_q <= pre_cnt_q + 6'd1;
                    end else if (sfd_accept_c) begin
                        state_q <= DATA;
                        slot_q  <= '0;
                        cnt_q   <= '0;
                        long_q  <= 1'b0;
                    end else begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    if (data_en_c) begin
                        cnt_q <= cnt_d;
                        if (last_slot_c) begin
                            axiov_q <= 1'b1;
                            axiod_q <= word_d;
                            slot_q  <= '0;
                        end else begin
                            buf_q  <= word_d;
                            slot_q <= slot_q + SLOT_W'(1);
                        end
                        if (too_long_c) begin
                            long_q  <= 1'b1;
                            state_q <= DROP;
                        end
                    end else begin
                        done_q   <= 1'b1;
                        status_q <= status_d;
                        state_q  <= IDLE;
                    end
                end
                DROP: begin
                    // Only an oversize frame owes its consumer a done pulse.
                    if (!rx.crsdv) begin
                        if (long_q) begin
                            done_q   <= 1'b1;
                            status_q <= status_d;
                        end
                        long_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx.axiov     = axiov_q;
    assign rx.axiod     = axiod_q;
    assign rx.done      = done_q;
    assign rx.err_align = status_q.err_align;
    assign rx.err_long  = status_q.err_long;
    assign rx.fcs_ok    = status_q.fcs_ok;
    assign rx.dibit_cnt = status_q.dibit_cnt;

endmodule

// File: tb/tb_ether_rx_framer.sv
// Directed bench: one 8-bit framer and one 32-bit framer with MAX_DIBITS=100 share the RMII stimulus.
module tb_ether_rx_framer;

`ifdef ETHER_RX_FCS_CHECK_EN
    localparam bit FCS_ON = 1'b1;
`else
    localparam bit FCS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       crsdv;
    logic [1:0] rxd;

    always #5 clk = ~clk;

    ether_rx_framer_if #(.OUT_W(8))  if_a ();
    ether_rx_framer_if #(.OUT_W(32)) if_b ();

    assign if_a.crsdv = crsdv;
    assign if_a.rxd   = rxd;
    assign if_b.crsdv = crsdv;
    assign if_b.rxd   = rxd;

    ether_rx_framer #(.OUT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .rx  (if_a)
    );

    ether_rx_framer #(.OUT_W(32), .MAX_DIBITS(100)) dut_b (
        .clk (clk),
        .rst (rst),
        .rx  (if_b)
    );

    typedef struct {
        bit junk;
        int pre_len;
        int n_data;
        bit add_fcs;
        int exp_words_a;
        bit exp_done_a;
        int exp_cnt_a;
        bit exp_align_a;
        bit exp_long_a;
        bit exp_fcs_a;
        int exp_words_b;
        bit exp_done_b;
        int exp_cnt_b;
        bit exp_align_b;
        bit exp_long_b;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  fbytes [0:2047];
    logic [31:0] wq_a[$];
    logic [31:0] wq_b[$];
    int          done_a, done_b;
    logic        st_align_a, st_long_a, st_fcs_a, st_align_b, st_long_b;
    logic [15:0] st_cnt_a, st_cnt_b;
    logic        overlap = 1'b0;

    // Collect words and frame-end status one time unit after each edge.
    always @(posedge clk) begin
        #1;
        if (if_a.axiov) wq_a.push_back(32'(if_a.axiod));
        if (if_b.axiov) wq_b.push_back(if_b.axiod);
        if (if_a.done) begin
            done_a++;
            st_align_a = if_a.err_align;
            st_long_a  = if_a.err_long;
            st_fcs_a   = if_a.fcs_ok;
            st_cnt_a   = if_a.dibit_cnt;
        end
        if (if_b.done) begin
            done_b++;
            st_align_b = if_b.err_align;
            st_long_b  = if_b.err_long;
            st_cnt_b   = if_b.dibit_cnt;
        end
        if ((if_a.axiov && if_a.done) || (if_b.axiov && if_b.done)) overlap = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [1:0] d);
        crsdv = c;
        rxd   = d;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        wq_a.delete();
        wq_b.delete();
        done_a = 0;
        done_b = 0;
    endtask

    // Fill the byte image of a frame; with add_fcs the last four bytes carry the FCS.
    task automatic build_bytes(input int n_data, input bit add_fcs, input int seed);
        int          nbytes;
        logic [31:0] crc;
        logic        fb;
        nbytes = (n_data + 3) / 4;
        for (int i = 0; i < nbytes; i++) fbytes[i] = 8'(i * 37 + seed);
        if (add_fcs) begin
            crc = 32'hFFFF_FFFF;
            for (int i = 0; i < nbytes - 4; i++) begin
                for (int b = 0; b < 8; b++) begin
                    fb  = crc[0] ^ fbytes[i][b];
                    crc = crc >> 1;
                    if (fb) crc = crc ^ 32'hEDB8_8320;
                end
            end
            crc = ~crc;
            for (int k = 0; k < 4; k++) fbytes[nbytes - 4 + k] = crc[8*k +: 8];
        end
    endtask

    task automatic send_data(input int n_data);
        for (int k = 0; k < n_data; k++) drive(1'b1, 2'(fbytes[k / 4] >> (2 * (k % 4))));
    endtask

    task automatic send_frame(input vec_t v);
        if (v.junk) begin
            drive(1'b1, 2'b11);
            drive(1'b1, 2'b00);
            drive(1'b1, 2'b01);
        end
        for (int p = 0; p < v.pre_len; p++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        send_data(v.n_data);
        drive(1'b0, 2'b00);
    endtask

    task automatic check_frame(input vec_t v, input int vi);
        int          m;
        logic [31:0] w;
        check($sformatf("v%0d_words_a", vi), 64'(wq_a.size()), 64'(v.exp_words_a));
        m = (wq_a.size() < v.exp_words_a) ? wq_a.size() : v.exp_words_a;
        for (int j = 0; j < m; j++)
            check($sformatf("v%0d_word_a%0d", vi, j), 64'(wq_a[j]), 64'(fbytes[j]));
        check($sformatf("v%0d_words_b", vi), 64'(wq_b.size()), 64'(v.exp_words_b));
        m = (wq_b.size() < v.exp_words_b) ? wq_b.size() : v.exp_words_b;
        for (int j = 0; j < m; j++) begin
            w = {fbytes[4*j+3], fbytes[4*j+2], fbytes[4*j+1], fbytes[4*j]};
            check($sformatf("v%0d_word_b%0d", vi, j), 64'(wq_b[j]), 64'(w));
        end
        check($sformatf("v%0d_done_a", vi), 64'(done_a), 64'(v.exp_done_a));
        check($sformatf("v%0d_done_b", vi), 64'(done_b), 64'(v.exp_done_b));
        if (v.exp_done_a && done_a == 1) begin
            check($sformatf("v%0d_cnt_a", vi),   64'(st_cnt_a),   64'(v.exp_cnt_a));
            check($sformatf("v%0d_align_a", vi), 64'(st_align_a), 64'(v.exp_align_a));
            check($sformatf("v%0d_long_a", vi),  64'(st_long_a),  64'(v.exp_long_a));
            check($sformatf("v%0d_fcs_a", vi),   64'(st_fcs_a),   64'(v.exp_fcs_a));
        end
        if (v.exp_done_b && done_b == 1) begin
            check($sformatf("v%0d_cnt_b", vi),  64'(st_cnt_b),  64'(v.exp_cnt_b));
            check($sformatf("v%0d_long_b", vi), 64'(st_long_b), 64'(v.exp_long_b));
            if (!v.exp_long_b)
                check($sformatf("v%0d_align_b", vi), 64'(st_align_b), 64'(v.exp_align_b));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_axiov_a"}, 64'(if_a.axiov),     64'd0);
        check({tag, "_axiod_a"}, 64'(if_a.axiod),     64'd0);
        check({tag, "_done_a"},  64'(if_a.done),      64'd0);
        check({tag, "_cnt_a"},   64'(if_a.dibit_cnt), 64'd0);
        check({tag, "_align_a"}, 64'(if_a.err_align), 64'd0);
        check({tag, "_long_b"},  64'(if_b.err_long),  64'd0);
        check({tag, "_axiod_b"}, 64'(if_b.axiod),     64'd0);
        check({tag, "_cnt_b"},   64'(if_b.dibit_cnt), 64'd0);
    endtask

    vec_t vecs [9];

    initial begin
        //            junk pre  n     fcs  wA    dA cntA  alA lgA fcsA          wB dB cntB alB lgB
        vecs[0] = '{1'b0, 31,  272, 1'b1, 68,   1, 272,  0,  0,  FCS_ON,       6, 1, 101, 0, 1};
        vecs[1] = '{1'b0, 10,  40,  1'b0, 0,    0, 0,    0,  0,  0,            0, 0, 0,   0, 0};
        vecs[2] = '{1'b0, 23,  40,  1'b0, 0,    0, 0,    0,  0,  0,            0, 0, 0,   0, 0};
        vecs[3] = '{1'b0, 24,  64,  1'b0, 16,   1, 64,   0,  0,  0,            4, 1, 64,  0, 0};
        vecs[4] = '{1'b1, 31,  40,  1'b0, 0,    0, 0,    0,  0,  0,            0, 0, 0,   0, 0};
        vecs[5] = '{1'b0, 31,  40,  1'b0, 10,   1, 40,   0,  0,  0,            2, 1, 40,  1, 0};
        vecs[6] = '{1'b0, 31,  6041, 1'b0, 1510, 1, 6041, 1,  0,  0,           6, 1, 101, 0, 1};
        vecs[7] = '{1'b0, 31,  100, 1'b0, 25,   1, 100,  0,  0,  0,            6, 1, 100, 1, 0};
        vecs[8] = '{1'b0, 31,  101, 1'b0, 25,   1, 101,  1,  0,  0,            6, 1, 101, 0, 1};

        rst   = 1'b1;
        crsdv = 1'b0;
        rxd   = 2'b00;
        clear_mon();
        for (int i = 0; i < 3; i++) drive(1'b0, 2'b00);
        check_zero("reset");
        rst = 1'b0;
        drive(1'b0, 2'b00);

        // One idle cycle between consecutive frames.
        for (int vi = 0; vi < 9; vi++) begin
            build_bytes(vecs[vi].n_data, vecs[vi].add_fcs, vi * 11 + 1);
            clear_mon();
            send_frame(vecs[vi]);
            check_frame(vecs[vi], vi);
        end

        // Reset in the middle of DATA: no done, outputs cleared, next frame clean.
        build_bytes(20, 1'b0, 99);
        clear_mon();
        for (int p = 0; p < 31; p++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        send_data(20);
        rst = 1'b1;
        drive(1'b1, 2'b10);
        rst = 1'b0;
        check_zero("midrst");
        check("midrst_words_a", 64'(wq_a.size()), 64'd5);
        for (int i = 0; i < 5; i++) drive(1'b1, 2'b10);
        drive(1'b0, 2'b00);
        drive(1'b0, 2'b00);
        check("midrst_words_a_after", 64'(wq_a.size()), 64'd5);
        check("midrst_done_a", 64'(done_a), 64'd0);
        check("midrst_done_b", 64'(done_b), 64'd0);

        build_bytes(vecs[3].n_data, 1'b0, 77);
        clear_mon();
        send_frame(vecs[3]);
        check_frame(vecs[3], 9);

        drive(1'b0, 2'b00);
        check("axiov_done_overlap", 64'(overlap), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
